// File: rtl/demorgan_pkg.sv
// Shared types and golden functions for the De Morgan sweep checker.
// Optional build macro used elsewhere: DEMORGAN_FIRST_FAIL_EN.
`ifndef DEMORGAN_PKG_SV
`define DEMORGAN_PKG_SV

`define DEMORGAN_COS(a, b) (~((a) | (b)))
`define DEMORGAN_COP(a, b) (~((a) & (b)))

package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Vector index width: {a,b} concatenated.
  function automatic int vec_w(input int width);
    return 2 * width;
  endfunction

endpackage

`endif

// File: rtl/demorgan_vec_gen.sv
// Vector index generator: owns the {a,b} index, the settle counter and the last-vector flag.
// Part of demorgan_sweep_checker (optional macro DEMORGAN_FIRST_FAIL_EN lives in the top).
module demorgan_vec_gen
  import demorgan_pkg::*;
#(
  parameter int VW            = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          drive_i,
  input  logic          step_i,
  output logic [VW-1:0] idx_o,
  output logic          settle_done_o,
  output logic          last_o
);

  localparam int CW = 4;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] idx_q, idx_d;

  assign settle_done_o = drive_i && (cnt_q == CW'(SETTLE_CYCLES - 1));
  assign last_o        = (idx_q == {VW{1'b1}});
  assign idx_o         = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
    end else if (step_i) begin
      idx_d = idx_q + VW'(1);
    end
  end

  // Counter only advances while a vector is being held; it is zero on every DRIVE entry.
  always_comb begin
    cnt_d = '0;
    if (drive_i && !settle_done_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps every {a,b} vector into the De Morgan unit, checks all four result buses, counts failures.
// Define DEMORGAN_FIRST_FAIL_EN to capture the first failing vector into first_fail.
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH-1:0]     cos_in,
  input  logic [WIDTH-1:0]     poc_in,
  input  logic [WIDTH-1:0]     cop_in,
  input  logic [WIDTH-1:0]     soc_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [2*WIDTH-1:0]   first_fail,
  output logic                 first_fail_vld
);

  localparam int VW = vec_w(WIDTH);
  localparam int EW = VW + 1;

  state_t          state_q;
  logic            busy_q, done_q, pass_q;
  logic [EW-1:0]   err_q, err_d;
  logic [VW-1:0]   idx;
  logic            settle_done, last_vec, start_acc, vec_fail;
  logic [WIDTH-1:0] a_v, b_v, gold_nor, gold_nand;

  // A sweep may also be accepted from DONE so a held start gives back-to-back sweeps.
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  demorgan_vec_gen #(
    .VW           (VW),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_vec_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (start_acc),
    .drive_i      (state_q == DRIVE),
    .step_i       ((state_q == CHECK) && !last_vec),
    .idx_o        (idx),
    .settle_done_o(settle_done),
    .last_o       (last_vec)
  );

  assign {a_v, b_v} = idx;
  assign a_out      = a_v;
  assign b_out      = b_v;
  assign gold_nor   = `DEMORGAN_COS(a_v, b_v);
  assign gold_nand  = `DEMORGAN_COP(a_v, b_v);
  assign vec_fail   = (cos_in != gold_nor) || (poc_in != gold_nor) ||
                      (cop_in != gold_nand) || (soc_in != gold_nand);

  always_comb begin
    err_d = err_q;
    if (vec_fail && (err_q != {EW{1'b1}})) begin
      err_d = err_q + EW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
          end
        end
        DRIVE: begin
          if (settle_done) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (last_vec) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= DRIVE;
          end
        end
        DONE: begin
          if (start) begin
            state_q <= DRIVE;
            pass_q  <= 1'b0;
            err_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

`ifdef DEMORGAN_FIRST_FAIL_EN
  logic [VW-1:0] ff_q;
  logic          ff_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_q     <= '0;
      ff_vld_q <= 1'b0;
    end else if (start_acc) begin
      ff_q     <= '0;
      ff_vld_q <= 1'b0;
    end else if ((state_q == CHECK) && vec_fail && !ff_vld_q) begin
      ff_q     <= idx;
      ff_vld_q <= 1'b1;
    end
  end

  assign first_fail     = ff_q;
  assign first_fail_vld = ff_vld_q;
`else
  assign first_fail     = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Self-checking bench for demorgan_sweep_checker: a behavioural De Morgan unit with injectable
// faults drives the checker; expected counts come from an arithmetic reference over all 16 vectors.
module tb_demorgan_sweep_checker;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, start3;
  logic [W-1:0] a_out, b_out, cos_in, poc_in, cop_in, soc_in;
  logic         busy, done, pass, first_fail_vld;
  logic [4:0]   err_cnt;
  logic [3:0]   first_fail;
  logic [W-1:0] a3, b3, cos3, poc3, cop3, soc3;
  logic         busy3, done3, pass3, ffv3;
  logic [4:0]   err3;
  logic [3:0]   ff3;

  int         fault_mode = 0;
  logic [7:0] mask [16];
  int         checks = 0;
  int         passed = 0;

  // Reference results packed as {cos,poc,cop,soc}; 2-bit complement is 3 - x.
  function automatic logic [7:0] golden(input int v);
    int a, b, nor_v, nand_v;
    a = v >> 2;
    b = v & 3;
    nor_v  = 3 - (a | b);
    nand_v = 3 - (a & b);
    return {nor_v[1:0], nor_v[1:0], nand_v[1:0], nand_v[1:0]};
  endfunction

  function automatic logic [7:0] unit_out(input int v, input int mode, input logic [7:0] m);
    logic [7:0] g;
    g = golden(v);
    case (mode)
      1: g[6] = 1'b0;               // cos[0] stuck-at-0
      2: g[1:0] = {g[0], g[1]};     // soc bits swapped
      3: g = g ^ m;                 // random corruption
      default: ;
    endcase
    return g;
  endfunction

  function automatic int exp_err(input int mode);
    int n = 0;
    for (int v = 0; v < 16; v++)
      if (unit_out(v, mode, mask[v]) != golden(v)) n++;
    return n;
  endfunction

  function automatic int exp_first(input int mode);
    for (int v = 0; v < 16; v++)
      if (unit_out(v, mode, mask[v]) != golden(v)) return v;
    return -1;
  endfunction

  always_comb {cos_in, poc_in, cop_in, soc_in} =
    unit_out(int'({a_out, b_out}), fault_mode, mask[{a_out, b_out}]);
  always_comb {cos3, poc3, cop3, soc3} = golden(int'({a3, b3}));

  demorgan_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
    .cos_in(cos_in), .poc_in(poc_in), .cop_in(cop_in), .soc_in(soc_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld)
  );

  demorgan_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3),
    .cos_in(cos3), .poc_in(poc3), .cop_in(cop3), .soc_in(soc3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_fail(ff3), .first_fail_vld(ffv3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start, follow the sweep to its done pulse; report done cycle and vector/busy anomalies.
  task automatic sweep(input int restart_at, output int done_cyc, output int vec_bad,
                       output int busy_bad);
    int ev;
    done_cyc = -1; vec_bad = 0; busy_bad = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      start = (k == restart_at);
      @(posedge clk); #1;
      ev = (k / 2 > 15) ? 15 : k / 2;
      if (int'({a_out, b_out}) != ev) vec_bad++;
      if (!busy) busy_bad++;
      if (done) begin done_cyc = k; break; end
    end
    start = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int mode, input int restart_at);
    int dc, vb, bb, ef;
    fault_mode = mode;
    sweep(restart_at, dc, vb, bb);
    check({tag, "_done_cycle"}, dc, 32);
    check({tag, "_vec_timing"}, vb, 0);
    check({tag, "_busy_during"}, bb, 0);
    check({tag, "_pass_at_done"}, pass, exp_err(mode) == 0);
    @(posedge clk); #1;
    check({tag, "_err_cnt"}, err_cnt, exp_err(mode));
    check({tag, "_pass"}, pass, exp_err(mode) == 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
    check({tag, "_hold_vec"}, {a_out, b_out}, 4'hF);
`ifdef DEMORGAN_FIRST_FAIL_EN
    ef = exp_first(mode);
    check({tag, "_ff_vld"}, first_fail_vld, ef >= 0);
    check({tag, "_ff"}, first_fail, (ef >= 0) ? ef : 0);
`else
    ef = 0;
    check({tag, "_ff_vld"}, first_fail_vld, ef);
    check({tag, "_ff"}, first_fail, ef);
`endif
    $display("sweep %s: mode=%0d err_cnt=%0d pass=%0b done_cycle=%0d", tag, mode, err_cnt, pass, dc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ab"}, {a_out, b_out}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_ff"}, {first_fail_vld, first_fail}, 0);
  endtask

  initial begin
    int d1, d2, n, vb, dones;
    for (int v = 0; v < 16; v++) mask[v] = 8'h00;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset3", {busy3, done3, pass3, err3, ffv3, ff3, a3, b3}, 0);
    rst_n = 1'b1;

    check_sweep("clean", 0, 0);
    check_sweep("cos0_stuck", 1, 0);
    check_sweep("soc_swap", 2, 0);
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 16; v++)
        mask[v] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      check_sweep($sformatf("random%0d", r), 3, 0);
    end
    check_sweep("start_while_busy", 0, 5);

    // Held start: consecutive done pulses 33 cycles apart.
    fault_mode = 0; d1 = -1; d2 = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done && d1 < 0) d1 = k;
      else if (done) begin d2 = k; break; end
    end
    start = 1'b0;
    check("b2b_first_done", d1, 32);
    check("b2b_spacing", d2 - d1, 33);
    check("b2b_err", err_cnt, 0);
    $display("back-to-back: done at %0d and %0d", d1, d2);
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_idle", busy, 0);

    // Reset 10 cycles into a sweep.
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done || busy) dones++; end
    check("midreset_quiet", dones, 0);
    $display("mid-sweep reset: outputs cleared, quiet cycles checked");
    check_sweep("after_reset", 0, 0);

    // SETTLE_CYCLES=3 instance: each vector held 4 cycles (3 settle + check).
    d1 = -1; vb = 0;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (int'({a3, b3}) != ((k / 4 > 15) ? 15 : k / 4)) vb++;
      if (done3) begin d1 = k; break; end
    end
    check("settle3_done_cycle", d1, 64);
    check("settle3_vec_timing", vb, 0);
    check("settle3_pass", pass3, 1);
    check("settle3_err", err3, 0);
    $display("settle3 sweep: done_cycle=%0d err_cnt=%0d", d1, err3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
